jitter_seed_sequencer: RTL and testbench

Front end for the 20-to-3-bit jitter PRNG. It accepts per-cell jitter requests (cell X/Y, frame number, tag) over a valid/ready handshake and packs each into a 20-bit seed. It strobes the PRNG on a free-running fixed period, so every seed gets the same number of PRNG rounds. It then pairs each 3-bit PRNG result with the tag of the request that produced it. It sits between the sprite/animation scheduler and the PRNG, which is instantiated alongside it by the parent.

---
 rtl/jitter_seed_sequencer_pkg.sv | 19 +
 rtl/jitter_seed_sequencer_strobe_divider.sv | 20 ++
 rtl/jitter_seed_sequencer.sv | 90 +++++++++
 tb/tb_jitter_seed_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jitter_seed_sequencer_pkg.sv
// Shared constants and seed packing for the jitter PRNG front end.
package jitter_seed_sequencer_pkg;
  localparam int SEED_W    = 20;
  localparam int JIT_W     = 3;
  localparam int FRAME_LSB = 12;
  localparam int Y_LSB     = 6;
  localparam int X_LSB     = 0;

  function automatic logic [SEED_W-1:0] pack_seed(input logic [7:0] frame,
                                                   input logic [5:0] y,
                                                   input logic [5:0] x);
    logic [SEED_W-1:0] s;
    s = '0;
    s[FRAME_LSB +: 8] = frame;
    s[Y_LSB +: 6]     = y;
    s[X_LSB +: 6]     = x;
    return s;
  endfunction
endpackage

// File: rtl/jitter_seed_sequencer_strobe_divider.sv
// Free-running period counter; strobe decoded from the count register only.
module jitter_seed_sequencer_strobe_divider #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic stb
);
  localparam logic [7:0] LAST = 8'(PERIOD - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= 8'd0;
    else if (cnt == LAST) cnt <= 8'd0;
    else                  cnt <= cnt + 8'd1;
  end

  assign stb = (cnt == LAST);
endmodule

// File: rtl/jitter_seed_sequencer.sv
// Packs jitter requests into PRNG seeds, strobes the PRNG at a fixed period
// and pairs each PRNG result with the tag of the request that produced it.
module jitter_seed_sequencer
  import jitter_seed_sequencer_pkg::*;
#(
  parameter int PERIOD = 8,
  parameter int TAG_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_x,
  input  logic [5:0]        req_y,
  input  logic [7:0]        req_frame,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [SEED_W-1:0] prng_inp,
  output logic              prng_stb,
  input  logic [JIT_W-1:0]  prng_out,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [JIT_W-1:0]  res_jitter
);
  logic              stb, stb_d, accept;
  logic              hold_v, fly_v, pend_v;
  logic [SEED_W-1:0] hold_seed;
  logic [TAG_W-1:0]  hold_tag, fly_tag, pend_tag;

  jitter_seed_sequencer_strobe_divider #(.PERIOD(PERIOD)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .stb   (stb)
  );

  assign accept    = req_valid && req_ready;
  assign req_ready = !hold_v;
  assign prng_stb  = stb;
  assign prng_inp  = hold_v ? hold_seed : '0;

  // An accept can only happen with hold empty, so in a strobe cycle it is
  // loaded for the next strobe rather than being swept into this one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v    <= 1'b0;
      hold_seed <= '0;
      hold_tag  <= '0;
    end else if (accept) begin
      hold_v    <= 1'b1;
      hold_seed <= pack_seed(req_frame, req_y, req_x);
      hold_tag  <= req_tag;
    end else if (stb) begin
      hold_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stb_d    <= 1'b0;
      fly_v    <= 1'b0;
      fly_tag  <= '0;
      pend_v   <= 1'b0;
      pend_tag <= '0;
    end else begin
      stb_d <= stb;
      if (stb) begin
        fly_v    <= hold_v;
        fly_tag  <= hold_tag;
        pend_v   <= fly_v;
        pend_tag <= fly_tag;
      end else if (stb_d) begin
        pend_v   <= 1'b0;
      end
    end
  end

  // prng_out carries the previous strobe's result only in the cycle after a strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_tag    <= '0;
      res_jitter <= '0;
    end else begin
      res_valid <= stb_d && pend_v;
      if (stb_d && pend_v) begin
        res_tag    <= pend_tag;
        res_jitter <= prng_out;
      end
    end
  end
endmodule

// File: tb/tb_jitter_seed_sequencer.sv
// Directed bench for jitter_seed_sequencer with a behavioural PRNG stand-in.
module tb_jitter_seed_sequencer;
  import jitter_seed_sequencer_pkg::*;

  localparam int PERIOD = 8;
  localparam int TAG_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_x, req_y;
  logic [7:0]        req_frame;
  logic [TAG_W-1:0]  req_tag;
  logic [SEED_W-1:0] prng_inp;
  logic              prng_stb;
  logic [JIT_W-1:0]  prng_out;
  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
  logic [JIT_W-1:0]  res_jitter;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  jitter_seed_sequencer #(.PERIOD(PERIOD), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_frame  (req_frame),
    .req_tag    (req_tag),
    .prng_inp   (prng_inp),
    .prng_stb   (prng_stb),
    .prng_out   (prng_out),
    .res_valid  (res_valid),
    .res_tag    (res_tag),
    .res_jitter (res_jitter)
  );

  always #5 clk = ~clk;

  // Golden PRNG function: any fixed mapping seed -> 3 bits.
  function automatic logic [2:0] jf(input logic [19:0] s);
    logic [2:0] a;
    a = 3'd5;
    for (int i = 0; i < 7; i++) a = {a[1:0], a[2]} ^ 3'(s >> (3 * i));
    return a;
  endfunction

  // PRNG stand-in: latches the seed on a strobe and presents its result only
  // in the cycle after the next strobe; other cycles show a corrupted value.
  logic [19:0] m_lat;
  logic [2:0]  m_r;
  logic        m_sd;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_lat <= '0; m_r <= '0; m_sd <= 1'b0;
    end else begin
      m_sd <= prng_stb;
      if (prng_stb) begin
        m_r   <= jf(m_lat);
        m_lat <= prng_inp;
      end
    end
  end
  assign prng_out = m_sd ? m_r : (m_r ^ 3'b101);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_x = '0; req_y = '0; req_frame = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic set_req(input logic v, input logic [5:0] x, input logic [5:0] y,
                         input logic [7:0] f, input logic [TAG_W-1:0] t);
    req_valid = v; req_x = x; req_y = y; req_frame = f; req_tag = t;
  endtask

  // Waits (bounded) for a result pulse; reports the cycle it was registered in.
  task automatic wait_res(input string nm, output int fire, output logic [TAG_W-1:0] t,
                          output logic [2:0] j);
    bit found = 0;
    fire = -1; t = '0; j = '0;
    for (int i = 0; i < 4 * PERIOD + 8 && !found; i++) begin
      if (res_valid) begin
        found = 1; fire = cyc - 1; t = res_tag; j = res_jitter;
      end else begin
        step();
      end
    end
    if (!found) chk({nm, " timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        valid;
    logic [5:0]  x, y;
    logic [7:0]  frame;
    logic [11:0] tag;
    logic        ready, stb, rv;
    logic [19:0] inp;
    logic [11:0] rtag;
    logic [2:0]  rjit;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc_n, res_n, fire, fire2;
    int acc_c[3], res_c[3];
    logic [TAG_W-1:0] res_t[3], t1, t2;
    logic [2:0] res_j[3], j1, j2;

    // Single-request trace, cycles 0..18
    for (int k = 0; k < 19; k++) begin
      tbl[k].valid = 0; tbl[k].x = 0; tbl[k].y = 0; tbl[k].frame = 0; tbl[k].tag = 0;
      tbl[k].ready = 1; tbl[k].stb = (k == 7 || k == 15); tbl[k].rv = 0;
      tbl[k].inp = 20'h0; tbl[k].rtag = 12'h0; tbl[k].rjit = 3'h0;
    end
    tbl[2].valid = 1; tbl[2].x = 6'd5; tbl[2].y = 6'd3; tbl[2].frame = 8'h12; tbl[2].tag = 12'h0AB;
    for (int k = 3; k <= 7; k++) begin
      tbl[k].ready = 0; tbl[k].inp = 20'h120C5;
    end
    tbl[17].rv = 1; tbl[17].rtag = 12'h0AB; tbl[17].rjit = jf(20'h120C5);

    // 1: idle after reset
    do_reset();
    chk("t1 rst res_valid", res_valid, 0);
    chk("t1 rst res_tag", res_tag, 0);
    chk("t1 rst res_jitter", res_jitter, 0);
    for (int k = 0; k < 25; k++) begin
      chk("t1 stb", prng_stb, (k % PERIOD == PERIOD - 1));
      chk("t1 inp", prng_inp, 0);
      chk("t1 res_valid", res_valid, 0);
      chk("t1 ready", req_ready, 1);
      step();
    end

    // 2: single request, table-driven
    do_reset();
    for (int k = 0; k < 19; k++) begin
      set_req(tbl[k].valid, tbl[k].x, tbl[k].y, tbl[k].frame, tbl[k].tag);
      chk("t2 ready", req_ready, tbl[k].ready);
      chk("t2 stb", prng_stb, tbl[k].stb);
      chk("t2 inp", prng_inp, tbl[k].inp);
      chk("t2 res_valid", res_valid, tbl[k].rv);
      if (tbl[k].rv) begin
        chk("t2 res_tag", res_tag, tbl[k].rtag);
        chk("t2 res_jitter", res_jitter, tbl[k].rjit);
      end
      step();
    end
    set_req(0, 0, 0, 0, 0);

    // 3: back-to-back with req_valid held
    do_reset();
    acc_n = 0; res_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (acc_n < 3) set_req(1, 6'(acc_n + 1), 6'(acc_n + 2), 8'((acc_n + 1) * 16), 12'(acc_n + 1));
      else set_req(0, 0, 0, 0, 0);
      if (req_valid && req_ready) begin acc_c[acc_n] = cyc; acc_n++; end
      if (res_valid) begin
        if (res_n < 3) begin res_c[res_n] = cyc - 1; res_t[res_n] = res_tag; res_j[res_n] = res_jitter; end
        res_n++;
      end
      step();
    end
    set_req(0, 0, 0, 0, 0);
    chk("t3 accept count", acc_n, 3);
    chk("t3 result count", res_n, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t3 accept cycle", acc_c[i], 8 * i);
      chk("t3 result cycle", res_c[i], 16 + 8 * i);
      chk("t3 result tag", res_t[i], i + 1);
      chk("t3 result jitter", res_j[i], jf(pack_seed(8'((i + 1) * 16), 6'(i + 2), 6'(i + 1))));
    end

    // 4: accept in a strobe cycle with hold empty; extreme field values
    do_reset();
    fire = -1;
    for (int k = 0; k < 30; k++) begin
      if (k == 7) set_req(1, 6'd63, 6'd0, 8'hFF, 12'hFFF);
      else set_req(0, 0, 0, 0, 0);
      if (k == 7) begin
        chk("t4 strobe@7", prng_stb, 1);
        chk("t4 ready@7", req_ready, 1);
        chk("t4 inp@7", prng_inp, 0);
      end
      if (k == 15) begin
        chk("t4 strobe@15", prng_stb, 1);
        chk("t4 inp@15", prng_inp, 20'hFF03F);
      end
      if (res_valid && fire < 0) begin fire = cyc - 1; t1 = res_tag; j1 = res_jitter; end
      step();
    end
    chk("t4 result cycle", fire, 24);
    chk("t4 result tag", t1, 12'hFFF);
    chk("t4 result jitter", j1, jf(20'hFF03F));

    // 5: reset at cycle 12 with one in flight and one held
    do_reset();
    acc_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (acc_n < 2) set_req(1, 6'd7, 6'd8, 8'h33, 12'(8'h11 * (acc_n + 1)));
      else set_req(0, 0, 0, 0, 0);
      if (req_valid && req_ready) acc_n++;
      step();
    end
    set_req(0, 0, 0, 0, 0);
    chk("t5 held before reset", req_ready, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    chk("t5 ready after reset", req_ready, 1);
    chk("t5 inp after reset", prng_inp, 0);
    chk("t5 res_tag after reset", res_tag, 0);
    for (int k = 0; k < 30; k++) begin
      chk("t5 no result", res_valid, 0);
      chk("t5 stb", prng_stb, (k % PERIOD == PERIOD - 1));
      step();
    end

    // 6: same seed twice, 100 periods apart
    do_reset();
    step(); step();
    set_req(1, 6'd9, 6'd17, 8'h40, 12'h123);
    step();
    set_req(0, 0, 0, 0, 0);
    wait_res("t6 first", fire, t1, j1);
    chk("t6 first cycle", fire, 16);
    chk("t6 first tag", t1, 12'h123);
    chk("t6 first jitter", j1, jf(pack_seed(8'h40, 6'd17, 6'd9)));
    repeat (100 * PERIOD) step();
    for (int i = 0; i < PERIOD && !req_ready; i++) step();
    set_req(1, 6'd9, 6'd17, 8'h40, 12'h456);
    step();
    set_req(0, 0, 0, 0, 0);
    wait_res("t6 second", fire2, t2, j2);
    chk("t6 second tag", t2, 12'h456);
    chk("t6 same jitter", j2, j1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
